// File: rtl/rsm_pkg.sv
// rtl/rsm_pkg.sv - shared encodings for the Simple RISC Machine controller, decoder and datapath
package rsm_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_CMP       = 3'd6,
    S_WRITE_REG = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [2:0] NSEL_NONE = 3'b000;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       err;
  } ctrl_t;

  function automatic logic is_legal(logic [2:0] opc, logic [1:0] op);
    return (opc == OPC_ALU) ||
           (opc == OPC_MOV && (op == OP_MOV_IMM || op == OP_MOV_REG));
  endfunction

  // Moore output table: a function of the state and the latched instruction only
  function automatic ctrl_t ctrl_for(state_t st, logic [2:0] opc, logic [1:0] op);
    ctrl_t c;
    c = '0;
    c.nsel = NSEL_NONE;
    c.vsel = VSEL_C;
    case (st)
      S_WAIT:      c.w = 1'b1;
      S_DECODE:    c.err = !is_legal(opc, op);
      S_WRITE_IMM: begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM8; c.write = 1'b1; end
      S_GET_A:     begin c.nsel = NSEL_RN; c.loada = 1'b1; end
      S_GET_B:     begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
      S_ALU:       begin
        c.loadc = 1'b1;
        c.asel  = (opc == OPC_MOV) || (opc == OPC_ALU && op == OP_MVN);
      end
      S_CMP:       c.loads = 1'b1;
      S_WRITE_REG: begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
      default:     c.w = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rsm_controller_fsm_if.sv
// rtl/rsm_controller_fsm_if.sv - decoder/datapath control bundle for the controller FSM
interface rsm_controller_fsm_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic [1:0] vsel;
  logic       write;
  logic       err;

  modport master (
    output s, opcode, op,
    input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err
  );
endinterface

// File: rtl/rsm_controller_fsm.sv
// rtl/rsm_controller_fsm.sv - one-instruction-at-a-time sequencer for the Simple RISC Machine datapath
module rsm_controller_fsm
  import rsm_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  rsm_controller_fsm_if.slave bus
);

  state_t     state, nxt;
  logic [2:0] opc_q, nxt_opc;
  logic [1:0] op_q,  nxt_op;
  ctrl_t      ctrl_q;

  always_comb begin
    nxt     = S_WAIT;
    nxt_opc = opc_q;
    nxt_op  = op_q;
    case (state)
      S_WAIT: begin
        nxt = S_WAIT;
        if (bus.s) begin
          nxt     = S_DECODE;
          nxt_opc = bus.opcode;
          nxt_op  = bus.op;
        end
      end
      S_DECODE: begin
        case ({opc_q, op_q})
          {OPC_MOV, OP_MOV_IMM}: nxt = S_WRITE_IMM;
          {OPC_MOV, OP_MOV_REG}: nxt = S_GET_B;
          {OPC_ALU, OP_ADD},
          {OPC_ALU, OP_AND},
          {OPC_ALU, OP_CMP}:     nxt = S_GET_A;
          {OPC_ALU, OP_MVN}:     nxt = S_GET_B;
          default:               nxt = S_WAIT;
        endcase
      end
      S_GET_A:     nxt = S_GET_B;
      S_GET_B:     nxt = (opc_q == OPC_ALU && op_q == OP_CMP) ? S_CMP : S_ALU;
      S_ALU:       nxt = S_WRITE_REG;
      default:     nxt = S_WAIT;
    endcase
  end

  // Outputs are registered alongside the state so they always match the state being entered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_WAIT;
      opc_q  <= 3'b000;
      op_q   <= 2'b00;
      ctrl_q <= ctrl_for(S_WAIT, 3'b000, 2'b00);
    end else begin
      state  <= nxt;
      opc_q  <= nxt_opc;
      op_q   <= nxt_op;
      ctrl_q <= ctrl_for(nxt, nxt_opc, nxt_op);
    end
  end

  assign bus.w     = ctrl_q.w;
  assign bus.nsel  = ctrl_q.nsel;
  assign bus.loada = ctrl_q.loada;
  assign bus.loadb = ctrl_q.loadb;
  assign bus.loadc = ctrl_q.loadc;
  assign bus.loads = ctrl_q.loads;
  assign bus.asel  = ctrl_q.asel;
  assign bus.bsel  = ctrl_q.bsel;
  assign bus.vsel  = ctrl_q.vsel;
  assign bus.write = ctrl_q.write;
  assign bus.err   = ctrl_q.err;

endmodule

// File: tb/tb_rsm_controller_fsm.sv
// tb/tb_rsm_controller_fsm.sv - directed self-checking bench for rsm_controller_fsm
module tb_rsm_controller_fsm;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  rsm_controller_fsm_if bus ();

  rsm_controller_fsm dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Observed vector: {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err}
  logic [13:0] obs;
  assign obs = {bus.w, bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                bus.asel, bus.bsel, bus.vsel, bus.write, bus.err};

  function automatic logic [13:0] mk(logic w, logic [2:0] nsel, logic la, logic lb,
                                     logic lc, logic ls, logic as, logic [1:0] vs,
                                     logic wr, logic er);
    return {w, nsel, la, lb, lc, ls, as, 1'b0, vs, wr, er};
  endfunction

  logic [13:0] v_wait, v_dec, v_dec_err, v_wimm, v_geta, v_getb, v_alu0, v_alu1, v_cmp, v_wreg;
  logic [13:0] expq[$];

  task automatic check(string tag, logic [13:0] got, logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Starts an instruction at a negedge and checks one expected vector per following cycle.
  task automatic play(string tag, logic [2:0] oc, logic [1:0] o, int release_at,
                      logic [2:0] oc2, logic [1:0] o2);
    bus.s = 1'b1; bus.opcode = oc; bus.op = o;
    for (int i = 0; i < expq.size(); i++) begin
      @(negedge clk);
      if (i == release_at) bus.s = 1'b0;
      if (i == 0) begin bus.opcode = oc2; bus.op = o2; end
      check($sformatf("%s[%0d]", tag, i), obs, expq[i]);
    end
    bus.s = 1'b0;
  endtask

  initial begin
    v_wait    = mk(1, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_dec     = mk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    v_dec_err = mk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1);
    v_wimm    = mk(0, 3'b100, 0, 0, 0, 0, 0, 2'b10, 1, 0);
    v_geta    = mk(0, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    v_getb    = mk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    v_alu0    = mk(0, 3'b000, 0, 0, 1, 0, 0, 2'b00, 0, 0);
    v_alu1    = mk(0, 3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 0);
    v_cmp     = mk(0, 3'b000, 0, 0, 0, 1, 0, 2'b00, 0, 0);
    v_wreg    = mk(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0);

    reset_n = 1'b0; bus.s = 1'b0; bus.opcode = 3'b000; bus.op = 2'b00;
    repeat (2) @(negedge clk);
    check("reset", obs, v_wait);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle", obs, v_wait);

    // MOV R0,#7: back in WAIT at the third edge
    expq = '{v_dec, v_wimm, v_wait};
    play("mov_imm", 3'b110, 2'b10, 0, 3'b110, 2'b10);

    // ADD with the decoder inputs scrambled after acceptance
    expq = '{v_dec, v_geta, v_getb, v_alu0, v_wreg, v_wait};
    play("add", 3'b101, 2'b00, 0, 3'b111, 2'b01);

    expq = '{v_dec, v_geta, v_getb, v_alu0, v_wreg, v_wait};
    play("and", 3'b101, 2'b10, 0, 3'b101, 2'b10);

    expq = '{v_dec, v_getb, v_alu1, v_wreg, v_wait};
    play("mov_reg", 3'b110, 2'b00, 0, 3'b110, 2'b00);

    // CMP then MVN with s held: WAIT occupied for exactly one cycle in between
    expq = '{v_dec, v_geta, v_getb, v_cmp, v_wait, v_dec, v_getb, v_alu1, v_wreg, v_wait, v_wait};
    play("cmp_mvn", 3'b101, 2'b01, 5, 3'b101, 2'b11);

    expq = '{v_dec_err, v_wait, v_wait};
    play("ill_111_00", 3'b111, 2'b00, 0, 3'b111, 2'b00);

    expq = '{v_dec_err, v_wait, v_wait};
    play("ill_110_01", 3'b110, 2'b01, 0, 3'b110, 2'b01);

    // Reset during GET_B of an ADD abandons it without a write
    bus.s = 1'b1; bus.opcode = 3'b101; bus.op = 2'b00;
    @(negedge clk); bus.s = 1'b0;
    check("rst_add_dec", obs, v_dec);
    @(negedge clk);
    check("rst_add_geta", obs, v_geta);
    @(negedge clk);
    check("rst_add_getb", obs, v_getb);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_add_wait", obs, v_wait);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_add_idle", obs, v_wait);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsm_controller_fsm.md
Name: rsm_controller_fsm

Overview:
Moore-style control FSM that sequences the Simple RISC Machine datapath through one instruction at a time. It takes opcode/op from the instruction decoder and a start strobe. It drives the decoder's one-hot register select (nsel) and every datapath load/select/write control. It returns to an idle WAIT state after each instruction and signals readiness on w.

Parameters:
None. All state and field encodings are constants in the shared package.

Ports:
clk  in  1  system clock; all state changes on rising edge
reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
s  in  1  start strobe; sampled only in WAIT
opcode  in  3  from instruction decoder, bits [15:13]
op  in  2  from instruction decoder, bits [12:11]
w  out  1  1 = idle in WAIT, ready for s
nsel  out  3  one-hot register select to decoder: 100=Rn, 010=Rd, 001=Rm, 000=none
loada  out  1  load datapath register A
loadb  out  1  load datapath register B
loadc  out  1  load datapath register C
loads  out  1  load status flags
asel  out  1  1 = ALU A-input forced to 16'b0
bsel  out  1  1 = ALU B-input from sximm5 (always 0 for the current ISA)
vsel  out  2  writeback source: 00=C, 01=PC (reserved), 10=sximm8, 11=mdata (reserved)
write  out  1  register file write enable
err  out  1  high for the whole DECODE cycle when the latched opcode/op is unsupported

Behaviour:
- Reset: reset_n=0 at a rising edge puts the FSM in WAIT. This applies from any state, including mid-instruction; the instruction in flight is abandoned with no write. Latched opcode/op clear to 0.
- Outputs are decoded from the state register and the latched opcode/op only, with no combinational path from s.
- Output values in reset/WAIT: w=1; all other outputs 0.
- Acceptance: in WAIT with s=1 at an edge, the FSM latches opcode/op and moves to DECODE. After that, opcode/op inputs and s are ignored until WAIT is re-entered.
- States: WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU, CMP, WRITE_REG.
- Per-state outputs (anything not listed is 0):
  - WAIT: w=1
  - DECODE: err as defined in the port list
  - WRITE_IMM: nsel=100, vsel=10, write=1
  - GET_A: nsel=100, loada=1
  - GET_B: nsel=001, loadb=1
  - ALU: asel=1 for MOV-reg and MVN, else asel=0; loadc=1
  - CMP: loads=1, asel=0
  - WRITE_REG: nsel=010, vsel=00, write=1
- Transitions out of DECODE, by {opcode,op}:
  - 110_10 MOV Rn,#imm8: WRITE_IMM -> WAIT
  - 110_00 MOV Rd,Rm{,sh}: GET_B -> ALU -> WRITE_REG -> WAIT
  - 101_00 ADD and 101_10 AND: GET_A -> GET_B -> ALU -> WRITE_REG -> WAIT
  - 101_01 CMP: GET_A -> GET_B -> CMP -> WAIT
  - 101_11 MVN: GET_B -> ALU -> WRITE_REG -> WAIT
  - any other code: err=1 in DECODE, then WAIT, with no load and no write
- Latency, counted in edges from acceptance back to WAIT (w=1 again): MOV-imm 3, MOV-reg 5, MVN 5, CMP 5, ADD/AND 6, illegal 2.
- In every state except WAIT, s=1 has no effect: no queueing, no re-trigger.
- s held high across the return to WAIT starts the next instruction immediately. WAIT is then occupied for exactly one cycle with w=1.
- MOV-reg relies on the decoder's ALUop=00 (ADD) combined with asel=1, so C = 0 + shifted Rm.
- Unreachable state encodings transition to WAIT.

Decomposition:
- Shared package rsm_pkg holds:
  - state enum
  - opcode constants OPC_MOV=3'b110, OPC_ALU=3'b101
  - op constants
  - NSEL_RN/RD/RM/NONE
  - VSEL_C/PC/IMM8/MDATA
- The decoder and the datapath top reuse the same package.
- No sub-module: a single state register plus next-state and output case blocks.

Test Plan:
- Reset and idle: reset_n=0 for 2 cycles, then 1 with s=0 -> w=1, all controls 0, err=0, state stays WAIT.
- MOV R0,#7 (opcode=110, op=10), s pulsed 1 cycle -> DECODE, then WRITE_IMM with nsel=100, vsel=10, write=1 -> w=1 exactly 3 edges after acceptance.
- ADD (101_00) -> loada with nsel=100, loadb with nsel=001, loadc with asel=0, write with nsel=010 and vsel=00 in consecutive cycles -> w=1 after 6 edges.
- CMP (101_01), then MVN (101_11) back-to-back with s held at 1 -> CMP asserts loads=1 and never write; WAIT lasts one cycle; MVN shows asel=1 in ALU and write in WRITE_REG.
- Illegal 111_00, and separately 110_01 -> err=1 only in the DECODE cycle, no load or write asserted, w=1 after 2 edges.
- reset_n=0 during GET_B of an ADD -> next edge in WAIT, write never asserted; opcode/op changed mid-instruction without reset do not alter the sequence.
